// File: rtl/rr_dec_arbiter.sv
// Round-robin arbiter for four requesters sharing one 2-to-4 decoder select path.
// Registered grant drives decoder A/E; break-before-make with bounded hold per owner.
module rr_dec_arbiter #(
    parameter int unsigned MAX_HOLD = 15,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_req,
    input  logic [3:0] i_done,
    output logic [1:0] o_gnt_idx,
    output logic       o_gnt_en,
    output logic [3:0] o_gnt,
    output logic       o_busy,
    output logic       o_timeout
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_ptr;
    logic [CNT_W-1:0]   r_hold;
    logic [CNT_W-1:0]   w_hold;
    logic [IDX_W-1:0]   r_gnt_idx;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               r_gnt_en;
    logic               w_gnt_en;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   w_gnt;
    logic               r_busy;
    logic               w_busy;
    logic               r_timeout;
    logic               w_timeout;

    logic               w_found;
    logic [IDX_W-1:0]   w_winner;
    logic [IDX_W-1:0]   w_cand;
    logic               w_rel_done;
    logic               w_rel_drop;
    logic               w_rel_max;

    assign w_rel_done = i_done[r_gnt_idx];
    assign w_rel_drop = ~i_req[r_gnt_idx];
    assign w_rel_max  = (r_hold == CNT_W'(MAX_HOLD));

    // Rotating priority scan: ptr+1 first, ptr itself last.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_cand   = r_ptr;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            w_cand = r_ptr + IDX_W'(k);
            if (!w_found && i_req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= IDX_W'(3);
            r_hold    <= '0;
            r_gnt_idx <= '0;
            r_gnt_en  <= 1'b0;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_ptr     <= w_ptr;
            r_hold    <= w_hold;
            r_gnt_idx <= w_gnt_idx;
            r_gnt_en  <= w_gnt_en;
            r_gnt     <= w_gnt;
            r_busy    <= w_busy;
            r_timeout <= w_timeout;
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        w_state   = r_state;
        w_ptr     = r_ptr;
        w_hold    = r_hold;
        w_gnt_idx = r_gnt_idx;
        w_gnt_en  = r_gnt_en;
        w_gnt     = r_gnt;
        w_busy    = r_busy;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_gnt_en = 1'b0;
                w_gnt    = '0;
                w_busy   = 1'b0;
                if (w_found) begin
                    w_state   = S_GRANT;
                    w_gnt_idx = w_winner;
                    w_gnt_en  = 1'b1;
                    w_gnt     = N_REQ'(1) << w_winner;
                    w_busy    = 1'b1;
                    w_hold    = CNT_W'(1);
                end
            end
            S_GRANT: begin
                if (w_rel_done || w_rel_drop || w_rel_max) begin
                    w_state   = S_IDLE;
                    w_gnt_en  = 1'b0;
                    w_gnt     = '0;
                    w_busy    = 1'b0;
                    w_ptr     = r_gnt_idx;
                    w_hold    = '0;
                    w_timeout = w_rel_max && !w_rel_done && !w_rel_drop;
                end else if (r_hold < CNT_W'(MAX_HOLD)) begin
                    w_hold = r_hold + CNT_W'(1);
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign o_gnt_idx = r_gnt_idx;
    assign o_gnt_en  = r_gnt_en;
    assign o_gnt     = r_gnt;
    assign o_busy    = r_busy;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// Self-checking bench for rr_dec_arbiter: directed scenarios then randomized traffic,
// all compared against an integer-level reference model of the arbitration rules.
module tb_rr_dec_arbiter;

    localparam int unsigned MAX_HOLD = 15;
    localparam int unsigned CNT_W    = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [1:0] gnt_idx;
    logic       gnt_en;
    logic [3:0] gnt;
    logic       busy;
    logic       timeout;

    int n_cmp;
    int n_mis;

    // reference model state
    bit m_busy;
    int m_idx;
    int m_ptr;
    int m_hold;
    bit m_to;

    rr_dec_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (req),
        .i_done    (done),
        .o_gnt_idx (gnt_idx),
        .o_gnt_en  (gnt_en),
        .o_gnt     (gnt),
        .o_busy    (busy),
        .o_timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of the reference model, using the inputs present at the edge.
    task automatic model_step();
        bit rel_a;
        bit rel_b;
        bit rel_c;
        if (rst) begin
            m_busy = 0; m_idx = 0; m_ptr = 3; m_hold = 0; m_to = 0;
        end else if (!m_busy) begin
            m_to = 0;
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (!m_busy && req[c]) begin
                    m_busy = 1; m_idx = c; m_hold = 1;
                end
            end
        end else begin
            rel_a = done[m_idx];
            rel_b = !req[m_idx];
            rel_c = (m_hold == int'(MAX_HOLD));
            if (rel_a || rel_b || rel_c) begin
                m_busy = 0; m_ptr = m_idx; m_hold = 0;
                m_to = rel_c && !rel_a && !rel_b;
            end else begin
                m_to = 0;
                if (m_hold < int'(MAX_HOLD)) m_hold++;
            end
        end
    endtask

    task automatic check_model();
        logic [3:0] exp_gnt;
        exp_gnt = m_busy ? (4'b0001 << m_idx) : 4'b0000;
        check("model_gnt_idx", 32'(gnt_idx), 32'(m_idx));
        check("model_gnt_en",  32'(gnt_en),  32'(m_busy));
        check("model_gnt",     32'(gnt),     32'(exp_gnt));
        check("model_busy",    32'(busy),    32'(m_busy));
        check("model_timeout", 32'(timeout), 32'(m_to));
        check("onehot", 32'($countones(gnt) <= 1), 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    initial begin
        int rr_exp[5];
        int waited;
        int n_hi;
        n_cmp = 0;
        n_mis = 0;
        m_busy = 0; m_idx = 0; m_ptr = 3; m_hold = 0; m_to = 0;
        rr_exp = '{0, 1, 2, 3, 0};
        rst = 1'b1; req = 4'hF; done = 4'h0;

        // 1: reset held with all requests
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_gnt_en", 32'(gnt_en), 32'd0);
            check("rst_gnt", 32'(gnt), 32'd0);
            check("rst_timeout", 32'(timeout), 32'd0);
        end

        // 2: single request released by done
        rst = 1'b0; req = 4'h0;
        tick();
        req = 4'b0100;
        tick();
        check("single_gnt", 32'(gnt), 32'b0100);
        check("single_idx", 32'(gnt_idx), 32'd2);
        check("single_en", 32'(gnt_en), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        done = 4'b0100;
        tick();
        done = 4'h0; req = 4'h0;
        check("single_rel_gnt", 32'(gnt), 32'd0);
        check("single_rel_busy", 32'(busy), 32'd0);
        check("single_rel_to", 32'(timeout), 32'd0);

        // 3: round-robin with done on third grant cycle
        rst = 1'b1; tick();
        rst = 1'b0; req = 4'hF;
        for (int r = 0; r < 5; r++) begin
            waited = 0;
            while (!gnt_en && waited < 4) begin
                tick();
                waited++;
            end
            check("rr_wait", 32'(waited), 32'd1);
            check("rr_owner", 32'(gnt_idx), 32'(rr_exp[r]));
            tick();
            tick();
            done = 4'b0001 << rr_exp[r];
            tick();
            done = 4'h0;
            check("rr_bbm", 32'(gnt_en), 32'd0);
        end

        // 4: timeout with a single held request
        rst = 1'b1; req = 4'b0001; tick();
        rst = 1'b0;
        tick();
        n_hi = 0;
        while (gnt == 4'b0001 && n_hi < 40) begin
            n_hi++;
            tick();
        end
        check("to_hold_len", 32'(n_hi), 32'(MAX_HOLD));
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_gnt_off", 32'(gnt), 32'd0);
        tick();
        check("to_regrant", 32'(gnt), 32'b0001);
        check("to_pulse_end", 32'(timeout), 32'd0);

        // 5: non-owner done/req activity ignored
        rst = 1'b1; req = 4'b0010; tick();
        rst = 1'b0;
        tick();
        check("ign_owner", 32'(gnt), 32'b0010);
        req = 4'b0011; tick();
        req = 4'b0010; done = 4'b1000; tick();
        done = 4'h0;
        check("ign_keep", 32'(gnt), 32'b0010);
        req = 4'b0000; tick();
        check("ign_drop_gnt", 32'(gnt), 32'd0);
        check("ign_drop_to", 32'(timeout), 32'd0);

        // 6: reset mid-grant restores ptr
        rst = 1'b1; req = 4'b0100; tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) tick();
        check("mid_pre", 32'(gnt), 32'b0100);
        rst = 1'b1; tick();
        check("mid_rst_en", 32'(gnt_en), 32'd0);
        check("mid_rst_idx", 32'(gnt_idx), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0; req = 4'b1100; tick();
        check("mid_after", 32'(gnt), 32'b0100);

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            end
            done = ($urandom_range(0, 5) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'h0;
            rst  = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
